// File: rtl/cube_pkg.sv
// Shared definitions for the cube plane-controller bus: command bytes,
// sequencer/phase state encodings and a counter-width helper.
package cube_pkg;

   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_ADDR_ZERO = 8'h02;
   localparam logic [7:0] CMD_DEC       = 8'h04;
   localparam logic [7:0] CMD_INC       = 8'h06;
   localparam logic [7:0] CMD_PWM_OFF   = 8'h08;
   localparam logic [7:0] CMD_PWM_ON    = 8'h0C;
   localparam logic [7:0] CMD_SET_ADDR  = 8'h80;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD_INC,
      S_CMD_ADDR,
      S_DATA,
      S_CMD_EN
   } seq_state_t;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_STROBE,
      PH_HOLD
   } phase_t;

   // Counters never collapse to zero width, even for a single plane/output.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/plane_bus_phy.sv
// Three-phase SETUP/STROBE/HOLD transfer generator for the shared plane bus.
// A request is loaded on entry to SETUP; data transfers may also capture in SETUP.
module plane_bus_phy
   import cube_pkg::*;
#(
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_req,
   input  logic [D_WIDTH-1:0] i_data,
   input  logic               i_rs,
   input  logic               i_go,
   input  logic               i_capture,
   input  logic               i_cancel,
   output logic [D_WIDTH-1:0] o_bus_data,
   output logic               o_bus_rs,
   output logic               o_bus_en,
   output logic               o_setup,
   output logic               o_xfer_done
);

   phase_t             r_phase, w_phase_nxt;
   logic [D_WIDTH-1:0] r_data,  w_data_nxt;
   logic               r_rs,    w_rs_nxt;
   logic               r_en;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_phase <= PH_IDLE;
         r_data  <= '0;
         r_rs    <= 1'b0;
         r_en    <= 1'b0;
      end else begin
         r_phase <= w_phase_nxt;
         r_data  <= w_data_nxt;
         r_rs    <= w_rs_nxt;
         r_en    <= (w_phase_nxt == PH_STROBE);
      end
   end

   // NOTE: every next-value signal gets a default first so no path infers a latch.
   always_comb begin
      w_phase_nxt = r_phase;
      w_data_nxt  = r_data;
      w_rs_nxt    = r_rs;
      case (r_phase)
         PH_IDLE, PH_HOLD: begin
            if (i_req) begin
               w_phase_nxt = PH_SETUP;
               w_data_nxt  = i_data;
               w_rs_nxt    = i_rs;
            end else begin
               w_phase_nxt = PH_IDLE;
            end
         end
         PH_SETUP: begin
            if (i_cancel) begin
               w_phase_nxt = PH_IDLE;
            end else if (i_go) begin
               w_phase_nxt = PH_STROBE;
               if (i_capture) w_data_nxt = i_data;
            end
         end
         PH_STROBE: w_phase_nxt = PH_HOLD;
         default:   w_phase_nxt = PH_IDLE;
      endcase
   end

   assign o_bus_data  = r_data;
   assign o_bus_rs    = r_rs;
   assign o_bus_en    = r_en;
   assign o_setup     = (r_phase == PH_SETUP);
   assign o_xfer_done = (r_phase == PH_HOLD);

endmodule

// File: rtl/cube_frame_sequencer.sv
// Streams one frame of PWM bytes into the cube's plane controllers, plane by
// plane: increment mode, address 0, OUT_NUM data writes, PWM enable.
module cube_frame_sequencer
   import cube_pkg::*;
#(
   parameter int PLANES  = 8,
   parameter int OUT_NUM = 64,
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   input  logic               src_valid,
   input  logic [D_WIDTH-1:0] src_data,
   output logic               src_ready,
   output logic [PLANES-1:0]  plane_sel,
   output logic [D_WIDTH-1:0] bus_data,
   output logic               bus_en,
   output logic               bus_rs
);

   localparam int BW = cnt_width(OUT_NUM);
   localparam int PW = cnt_width(PLANES);

   seq_state_t        r_state, w_state_nxt;
   logic [BW-1:0]     r_byte,  w_byte_nxt;
   logic [PW-1:0]     r_plane, w_plane_nxt;
   logic [PLANES-1:0] r_sel,   w_sel_nxt;
   logic              r_done,  w_done_nxt;
   logic              r_abort_pend, w_abort_pend_nxt;

   logic               w_req, w_req_rs, w_go, w_capture, w_cancel;
   logic [D_WIDTH-1:0] w_req_data;
   logic               w_setup, w_xfer_done, w_abort, w_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_byte       <= '0;
         r_plane      <= '0;
         r_sel        <= '0;
         r_done       <= 1'b0;
         r_abort_pend <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_byte       <= w_byte_nxt;
         r_plane      <= w_plane_nxt;
         r_sel        <= w_sel_nxt;
         r_done       <= w_done_nxt;
         r_abort_pend <= w_abort_pend_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_byte_nxt  = r_byte;
      w_plane_nxt = r_plane;
      w_sel_nxt   = r_sel;
      w_done_nxt  = 1'b0;
      w_req       = 1'b0;
      w_req_data  = bus_data;
      w_req_rs    = 1'b0;
      w_go        = 1'b1;
      w_capture   = 1'b0;
      w_cancel    = 1'b0;
      w_ready     = 1'b0;
      w_abort     = abort | r_abort_pend;

      case (r_state)
         S_IDLE: begin
            if (start && !abort) begin
               w_req       = 1'b1;
               w_req_data  = D_WIDTH'(CMD_INC);
               w_req_rs    = 1'b1;
               w_state_nxt = S_CMD_INC;
               w_plane_nxt = '0;
               w_byte_nxt  = '0;
               w_sel_nxt   = PLANES'(1);
            end
         end
         S_DATA: begin
            // The data SETUP waits on the stream; an abort leaves it at once.
            if (w_setup) begin
               w_ready    = !w_abort;
               w_go       = src_valid && !w_abort;
               w_capture  = 1'b1;
               w_req_data = src_data;
               w_cancel   = w_abort;
               if (w_abort) begin
                  w_state_nxt = S_IDLE;
                  w_sel_nxt   = '0;
               end
            end
         end
         default: ;
      endcase

      if (w_xfer_done) begin
         if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_sel_nxt   = '0;
         end else begin
            case (r_state)
               S_CMD_INC: begin
                  w_req       = 1'b1;
                  w_req_data  = D_WIDTH'(CMD_SET_ADDR);
                  w_req_rs    = 1'b1;
                  w_state_nxt = S_CMD_ADDR;
               end
               S_CMD_ADDR: begin
                  w_req       = 1'b1;
                  w_state_nxt = S_DATA;
               end
               S_DATA: begin
                  w_req = 1'b1;
                  if (r_byte == BW'(OUT_NUM - 1)) begin
                     w_byte_nxt  = '0;
                     w_req_data  = D_WIDTH'(CMD_PWM_ON);
                     w_req_rs    = 1'b1;
                     w_state_nxt = S_CMD_EN;
                  end else begin
                     w_byte_nxt  = r_byte + BW'(1);
                  end
               end
               S_CMD_EN: begin
                  if (r_plane == PW'(PLANES - 1)) begin
                     w_state_nxt = S_IDLE;
                     w_sel_nxt   = '0;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_plane_nxt = r_plane + PW'(1);
                     w_sel_nxt   = r_sel << 1;
                     w_req       = 1'b1;
                     w_req_data  = D_WIDTH'(CMD_INC);
                     w_req_rs    = 1'b1;
                     w_state_nxt = S_CMD_INC;
                  end
               end
               default: ;
            endcase
         end
      end

      w_abort_pend_nxt = (r_state != S_IDLE) && w_abort && (w_state_nxt != S_IDLE);
   end

   plane_bus_phy #(.D_WIDTH(D_WIDTH)) u_phy (
      .clk         (clk),
      .reset       (reset),
      .i_req       (w_req),
      .i_data      (w_req_data),
      .i_rs        (w_req_rs),
      .i_go        (w_go),
      .i_capture   (w_capture),
      .i_cancel    (w_cancel),
      .o_bus_data  (bus_data),
      .o_bus_rs    (bus_rs),
      .o_bus_en    (bus_en),
      .o_setup     (w_setup),
      .o_xfer_done (w_xfer_done)
   );

   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign src_ready = w_ready;
   assign plane_sel = r_sel;

endmodule

// File: tb/tb_cube_frame_sequencer.sv
// Directed bench for cube_frame_sequencer (2 planes x 4 outputs) with a
// stream source and a behavioural plane-controller model on the bus.
module tb_cube_frame_sequencer;

   localparam int NP = 2;
   localparam int NO = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          src_valid = 1'b0;
   logic [DW-1:0] src_data = '0;
   logic          busy, done, src_ready, bus_en, bus_rs;
   logic [NP-1:0] plane_sel;
   logic [DW-1:0] bus_data;

   cube_frame_sequencer #(.PLANES(NP), .OUT_NUM(NO), .D_WIDTH(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .src_valid (src_valid),
      .src_data  (src_data),
      .src_ready (src_ready),
      .plane_sel (plane_sel),
      .bus_data  (bus_data),
      .bus_en    (bus_en),
      .bus_rs    (bus_rs)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Stream source with an optional stall of stall_left ready cycles at byte stall_idx.
   logic [7:0] src_bytes[$];
   int  src_idx = 0;
   bit  src_en = 1'b0;
   bit  hs = 1'b0;
   int  stall_idx = -1, stall_left = 0, stall_seen = 0, stall_bad = 0;

   initial forever begin
      @(posedge clk);
      #2;
      if (hs) src_idx++;
      hs = 1'b0;
      if (src_ready && src_idx == stall_idx && stall_left > 0) begin
         src_valid = 1'b0;
         stall_left--;
         stall_seen++;
         if (bus_en !== 1'b0 || plane_sel !== 2'b01) stall_bad++;
      end else begin
         src_valid = src_en && (src_idx < src_bytes.size());
         src_data  = src_valid ? src_bytes[src_idx] : 8'h00;
      end
      @(negedge clk);
      hs = src_valid && src_ready;
   end

   // Plane-controller model: commits on the falling edge of bus_en.
   logic [7:0]  mem [NP][64];
   logic        pwm [NP];
   int          addr [NP];
   bit          inc_mode [NP];
   logic [31:0] lg[$];
   int          done_cnt = 0;
   logic        prev_en = 1'b0;

   task automatic model_clear();
      for (int p = 0; p < NP; p++) begin
         for (int a = 0; a < 64; a++) mem[p][a] = 8'h00;
         pwm[p] = 1'b0;
         addr[p] = 0;
         inc_mode[p] = 1'b1;
      end
   endtask

   task automatic model_apply(input int p, input logic rs, input logic [7:0] d);
      if (rs) begin
         case (d)
            8'h01: begin for (int a = 0; a < 64; a++) mem[p][a] = 8'h00; addr[p] = 0; end
            8'h02: addr[p] = 0;
            8'h04: inc_mode[p] = 1'b0;
            8'h06: inc_mode[p] = 1'b1;
            8'h08: pwm[p] = 1'b0;
            8'h0C: pwm[p] = 1'b1;
            default: if (d[7]) addr[p] = int'(d[5:0]);
         endcase
      end else begin
         mem[p][addr[p]] = d;
         addr[p] = inc_mode[p] ? (addr[p] + 1) % 64 : (addr[p] + 63) % 64;
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (reset && prev_en && !bus_en) begin
         lg.push_back({21'd0, plane_sel, bus_rs, bus_data});
         for (int p = 0; p < NP; p++)
            if (plane_sel[p]) model_apply(p, bus_rs, bus_data);
      end
      prev_en = bus_en;
   end

   logic [31:0] exp_q[$];

   task automatic add_plane(input int p, input logic [7:0] first, input int nb, input bit with_en);
      logic [1:0] s;
      s = 2'(1 << p);
      exp_q.push_back({21'd0, s, 1'b1, 8'h06});
      exp_q.push_back({21'd0, s, 1'b1, 8'h80});
      for (int i = 0; i < nb; i++) exp_q.push_back({21'd0, s, 1'b0, first + 8'(i)});
      if (with_en) exp_q.push_back({21'd0, s, 1'b1, 8'h0C});
   endtask

   task automatic check_seq(input string tag);
      check({tag, "_len"}, lg.size(), exp_q.size());
      for (int i = 0; i < lg.size() && i < exp_q.size(); i++)
         check($sformatf("%s_x%0d", tag, i), lg[i], exp_q[i]);
   endtask

   task automatic prep(input logic [7:0] first);
      src_en = 1'b0;
      src_bytes.delete();
      for (int i = 0; i < NP * NO; i++) src_bytes.push_back(first + 8'(i));
      src_idx = 0;
      stall_idx = -1;
      stall_left = 0;
      lg.delete();
      exp_q.delete();
      model_clear();
      done_cnt = 0;
      src_en = 1'b1;
   endtask

   task automatic start_frame(input string tag, output int c0);
      @(posedge clk);
      #1;
      start = 1'b1;
      c0 = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_busy"}, busy, 1);
      check({tag, "_first_cmd"}, {plane_sel, bus_rs, bus_en, bus_data}, {2'b01, 1'b1, 1'b0, 8'h06});
   endtask

   task automatic wait_done(input int budget, output bit ok, output int dc);
      ok = 1'b0;
      dc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            dc = cyc;
            break;
         end
      end
   endtask

   initial begin
      int c0, dc, n, sz;
      bit ok;

      #1 reset = 1'b0;
      #3;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", src_ready, 0);
      check("rst_sel", plane_sel, 0);
      check("rst_data", bus_data, 0);
      check("rst_en", bus_en, 0);
      check("rst_rs", bus_rs, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      model_clear();

      // Full frame, source always valid.
      prep(8'h01);
      start_frame("t1", c0);
      wait_done(200, ok, dc);
      check("t1_done_seen", ok, 1);
      check("t1_done_lat", dc - c0, 43);
      check("t1_busy_at_done", busy, 0);
      add_plane(0, 8'h01, NO, 1'b1);
      add_plane(1, 8'h05, NO, 1'b1);
      check_seq("t1_seq");
      repeat (4) @(negedge clk);
      check("t1_done_pulses", done_cnt, 1);
      for (int p = 0; p < NP; p++) begin
         for (int i = 0; i < NO; i++)
            check($sformatf("t1_mem%0d_%0d", p, i), mem[p][i], 8'(1 + p * NO + i));
         check($sformatf("t1_pwm%0d", p), pwm[p], 1);
      end

      // start together with abort in IDLE: nothing starts.
      prep(8'h01);
      @(posedge clk);
      #1;
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      check("t1b_busy", busy, 0);
      repeat (6) @(negedge clk);
      check("t1b_no_xfer", lg.size(), 0);

      // Stream stalls 10 cycles at the second byte of plane 0.
      prep(8'h11);
      stall_idx = 1;
      stall_left = 10;
      stall_seen = 0;
      stall_bad = 0;
      start_frame("t2", c0);
      wait_done(300, ok, dc);
      check("t2_done_seen", ok, 1);
      check("t2_done_lat", dc - c0, 53);
      check("t2_stall_cycles", stall_seen, 10);
      check("t2_stall_bus", stall_bad, 0);
      add_plane(0, 8'h11, NO, 1'b1);
      add_plane(1, 8'h15, NO, 1'b1);
      check_seq("t2_seq");

      // Abort during STROBE of the third data byte.
      prep(8'h21);
      start_frame("t3", c0);
      n = 0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus_en && !bus_rs) n++;
         if (n == 3) begin ok = 1'b1; break; end
      end
      check("t3_reach_strobe", ok, 1);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("t3_hold", {busy, bus_en, plane_sel}, {1'b1, 1'b0, 2'b01});
      @(posedge clk);
      #1;
      check("t3_idle", {busy, bus_en, plane_sel}, {1'b0, 1'b0, 2'b00});
      repeat (10) @(negedge clk);
      check("t3_no_done", done_cnt, 0);
      add_plane(0, 8'h21, 3, 1'b0);
      check_seq("t3_seq");
      check("t3_mem", {mem[0][0], mem[0][1], mem[0][2], mem[0][3]}, 32'h21222300);
      check("t3_pwm", pwm[0], 0);

      // start pulsed while busy is ignored.
      prep(8'h31);
      start_frame("t4", c0);
      repeat (5) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (15) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(200, ok, dc);
      check("t4_done_lat", dc - c0, 43);
      repeat (60) @(negedge clk);
      check("t4_done_pulses", done_cnt, 1);
      add_plane(0, 8'h31, NO, 1'b1);
      add_plane(1, 8'h35, NO, 1'b1);
      check_seq("t4_seq");

      // Asynchronous reset in the middle of a data STROBE.
      prep(8'h41);
      start_frame("t5", c0);
      n = 0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus_en && !bus_rs) n++;
         if (n == 2) begin ok = 1'b1; break; end
      end
      check("t5_reach_strobe", ok, 1);
      sz = lg.size();
      #2 reset = 1'b0;
      #1;
      check("t5_async", {busy, bus_en, plane_sel, done}, {1'b0, 1'b0, 2'b00, 1'b0});
      repeat (3) @(negedge clk);
      check("t5_no_partial", lg.size(), sz);
      reset = 1'b1;
      prep(8'h51);
      start_frame("t5r", c0);
      wait_done(200, ok, dc);
      check("t5r_done_lat", dc - c0, 43);
      add_plane(0, 8'h51, NO, 1'b1);
      add_plane(1, 8'h55, NO, 1'b1);
      check_seq("t5r_seq");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
